// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control path:
// hazard-controller state encodings, register-address width and control bundles.
package riscv_pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_FETCH_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH      = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_flush;
        logic pipe_freeze;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = 6'b110000;
    localparam pipe_ctrl_t CTRL_STALL  = 6'b000100;
    localparam pipe_ctrl_t CTRL_FLUSH  = 6'b111110;
    localparam pipe_ctrl_t CTRL_FREEZE = 6'b000001;
    localparam pipe_ctrl_t CTRL_RESET  = 6'b001110;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_mem_read,
    output logic              o_load_use
);

    logic w_rd_nonzero;
    logic w_src_match;

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign w_rd_nonzero = (i_rd != {REG_AW{1'b0}});
    assign w_src_match  = (i_rd == i_rs1) || (i_rd == i_rs2);
    assign o_load_use   = i_mem_read && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: combinational stall/flush/freeze decode from a small
// wait-state FSM, plus stall and flush event counters.
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = riscv_pipe_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              ex_mem_branch_taken,
    input  logic              ex_mem_mem_access,
    input  logic              dmem_ready,
    input  logic              imem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_flush,
    output logic              pipe_freeze,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_load_use;
    logic             w_dmem_wait;
    logic             w_freeze;
    logic             w_flush;
    pipe_ctrl_t       w_ctrl;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .i_rs1      (if_id_rs1),
        .i_rs2      (if_id_rs2),
        .i_rd       (id_ex_rd),
        .i_mem_read (id_ex_mem_read),
        .o_load_use (w_load_use)
    );

    // MEM_WAIT holds until dmem completes even if the access strobe drops meanwhile.
    // A branch seen in FLUSH is the already-flushed slot and must not flush again.
    assign w_dmem_wait = !dmem_ready && ((r_state == ST_MEM_WAIT) || ex_mem_mem_access);
    assign w_freeze    = w_dmem_wait || !imem_ready;
    assign w_flush     = ex_mem_branch_taken && !w_freeze && (r_state != ST_FLUSH);

    // Next-state selection: dmem wait dominates fetch wait, both dominate a flush
    always_comb begin
        w_state_nxt = ST_RUN;
        if (w_dmem_wait) begin
            w_state_nxt = ST_MEM_WAIT;
        end else if (!imem_ready) begin
            w_state_nxt = ST_FETCH_WAIT;
        end else if (w_flush) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    // Control decode with priority reset > freeze > flush > load-use > run
    always_comb begin
        w_ctrl = CTRL_RUN;
        if (reset) begin
            w_ctrl = CTRL_RESET;
        end else if (w_freeze) begin
            w_ctrl = CTRL_FREEZE;
        end else if (w_flush) begin
            w_ctrl = CTRL_FLUSH;
        end else if (w_load_use) begin
            w_ctrl = CTRL_STALL;
        end else begin
            w_ctrl = CTRL_RUN;
        end
    end

    // State register and wrapping event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (!w_ctrl.pc_write) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_write     = w_ctrl.pc_write;
    assign if_id_write  = w_ctrl.if_id_write;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_bubble = w_ctrl.id_ex_bubble;
    assign ex_mem_flush = w_ctrl.ex_mem_flush;
    assign pipe_freeze  = w_ctrl.pipe_freeze;
    assign state_o      = reset ? ST_RUN : r_state;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
